// File: rtl/gcd_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// gcd_ctrl_fsm
//
// Control unit of a subtractive GCD engine. Each iteration it reads the
// magnitude comparator flags (eq/lt/gt) and the zero detectors of the X and Y
// datapath registers. From these it drives the register load enables, the
// input mux and the subtract direction. It also runs the start/done/ack
// handshake with the host. The number of subtractions per job is bounded.
// Zero operands, illegal flag combinations and timeouts end the job with err_o.
//
// Handshake: the host raises start_i, which is taken on a rising edge where
// ready_o=1. The result is presented with done_o=1, together with err_o and
// iter_o, and is held until a rising edge where ack_i=1. Both inputs are level
// sampled. start_i outside IDLE and ack_i outside DONE are ignored.
//
// Ports
//   clk         in   1       rising-edge clock
//   rst_n       in   1       asynchronous active-low reset
//   start_i     in   1       host request, accepted in IDLE
//   ack_i       in   1       host acknowledge of done_o
//   eq_i        in   1       comparator X==Y
//   lt_i        in   1       comparator X<Y
//   gt_i        in   1       comparator X>Y
//   x_zero_i    in   1       X register is zero
//   y_zero_i    in   1       Y register is zero
//   ready_o     out  1       IDLE, start_i will be accepted
//   busy_o      out  1       LOAD/CMP/SUB_X/SUB_Y
//   ld_x_o      out  1       X register load enable
//   ld_y_o      out  1       Y register load enable
//   sel_in_o    out  1       1: load external operands, 0: subtractor result
//   sub_dir_o   out  1       0: X<=X-Y, 1: Y<=Y-X
//   done_o      out  1       result available
//   err_o       out  1       job ended in error (valid with done_o)
//   iter_o      out  ITER_W  subtractions in current/last job
//   dbg_state_o out  3       current FSM state encoding
// ----------------------------------------------------------------------------
module gcd_ctrl_fsm #(
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              ack_i,
    input  logic              eq_i,
    input  logic              lt_i,
    input  logic              gt_i,
    input  logic              x_zero_i,
    input  logic              y_zero_i,
    output logic              ready_o,
    output logic              busy_o,
    output logic              ld_x_o,
    output logic              ld_y_o,
    output logic              sel_in_o,
    output logic              sub_dir_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ITER_W-1:0] iter_o,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CMP   = 3'd2,
        S_SUB_X = 3'd3,
        S_SUB_Y = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [ITER_W-1:0] MAX_ITER_C = ITER_W'(MAX_ITER);

    state_t             state_q, state_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic               err_q, err_d;
    logic               flags_one_hot;

    // Exactly one comparator flag is legal; anything else means the
    // comparator or its wiring is broken.
    assign flags_one_hot = ({eq_i, lt_i, gt_i} == 3'b100) ||
                           ({eq_i, lt_i, gt_i} == 3'b010) ||
                           ({eq_i, lt_i, gt_i} == 3'b001);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            err_q   <= err_d;
        end
    end

    // Next state plus iteration counter and error flag.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                iter_d  = '0;
                err_d   = 1'b0;
                state_d = S_CMP;
            end
            S_CMP: begin
                if (x_zero_i || y_zero_i) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else if (!flags_one_hot) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else if (eq_i) begin
                    state_d = S_DONE;
                    err_d   = 1'b0;
                end else if (iter_q == MAX_ITER_C) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else if (gt_i) begin
                    state_d = S_SUB_X;
                end else begin
                    // Flags are one-hot and neither eq nor gt, so lt is set.
                    state_d = S_SUB_Y;
                end
            end
            S_SUB_X, S_SUB_Y: begin
                // CMP already stops at MAX_ITER; the guard keeps the counter
                // from wrapping.
                if (iter_q != MAX_ITER_C) begin
                    iter_d = iter_q + ITER_W'(1);
                end
                state_d = S_CMP;
            end
            S_DONE: begin
                if (ack_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore output decode.
    always_comb begin
        ready_o   = 1'b0;
        busy_o    = 1'b0;
        ld_x_o    = 1'b0;
        ld_y_o    = 1'b0;
        sel_in_o  = 1'b0;
        sub_dir_o = 1'b0;
        done_o    = 1'b0;
        unique case (state_q)
            S_IDLE: ready_o = 1'b1;
            S_LOAD: begin
                busy_o   = 1'b1;
                ld_x_o   = 1'b1;
                ld_y_o   = 1'b1;
                sel_in_o = 1'b1;
            end
            S_CMP: busy_o = 1'b1;
            S_SUB_X: begin
                busy_o = 1'b1;
                ld_x_o = 1'b1;
            end
            S_SUB_Y: begin
                busy_o    = 1'b1;
                ld_y_o    = 1'b1;
                sub_dir_o = 1'b1;
            end
            S_DONE: done_o = 1'b1;
            default: ready_o = 1'b0;
        endcase
    end

    assign err_o       = err_q;
    assign iter_o      = iter_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gcd_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// tb_gcd_ctrl_fsm
//
// Bench for gcd_ctrl_fsm (MAX_ITER=4). It contains a behavioural X/Y datapath
// that is steered by the DUT's control outputs, and a comparator model that
// generates the flags. The driver pushes a hand-computed expected record per
// job. The monitor measures the latency and the load pulses of each job and
// checks the result when done_o rises.
// Expected record layout: {err, iter[7:0], x[7:0], latency[7:0], loads[7:0]}.
// ----------------------------------------------------------------------------
module tb_gcd_ctrl_fsm;

    localparam int W = 33;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i, ack_i;
    logic       eq_i, lt_i, gt_i, x_zero_i, y_zero_i;
    logic       ready_o, busy_o, ld_x_o, ld_y_o, sel_in_o, sub_dir_o;
    logic       done_o, err_o;
    logic [7:0] iter_o;
    logic [2:0] dbg_state_o;

    logic [7:0] x_r, y_r, a_in, b_in;
    logic       force_bad;

    logic [W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gcd_ctrl_fsm #(.ITER_W(8), .MAX_ITER(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .ack_i(ack_i),
        .eq_i(eq_i), .lt_i(lt_i), .gt_i(gt_i),
        .x_zero_i(x_zero_i), .y_zero_i(y_zero_i),
        .ready_o(ready_o), .busy_o(busy_o), .ld_x_o(ld_x_o), .ld_y_o(ld_y_o),
        .sel_in_o(sel_in_o), .sub_dir_o(sub_dir_o), .done_o(done_o),
        .err_o(err_o), .iter_o(iter_o), .dbg_state_o(dbg_state_o)
    );

    // Datapath and comparator model.
    always @(posedge clk) begin
        if (ld_x_o) x_r <= sel_in_o ? a_in : (x_r - y_r);
        if (ld_y_o) y_r <= sel_in_o ? b_in : (y_r - x_r);
    end
    assign eq_i     = force_bad ? 1'b1 : (x_r == y_r);
    assign gt_i     = force_bad ? 1'b1 : (x_r > y_r);
    assign lt_i     = force_bad ? 1'b0 : (x_r < y_r);
    assign x_zero_i = (x_r == 8'd0);
    assign y_zero_i = (y_r == 8'd0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: the latency is counted in rising edges from the start-accept edge.
    initial begin
        bit         in_job;
        bit         done_prev;
        int         lat;
        int         nld;
        logic [W-1:0] e;
        in_job = 0; done_prev = 0; lat = 0; nld = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_job = 0;
                done_prev = 0;
            end else begin
                if (busy_o && !in_job) begin
                    in_job = 1; lat = 1; nld = 0;
                end else if (in_job) begin
                    lat++;
                end
                if (in_job && (ld_x_o || ld_y_o)) nld++;
                if (done_o && !done_prev) begin
                    in_job = 0;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: got done_o=1 expected no job");
                    end else begin
                        e = exp_q.pop_front();
                        chk("err", {31'd0, err_o}, {31'd0, e[32]});
                        chk("iter", {24'd0, iter_o}, {24'd0, e[31:24]});
                        if (!e[32]) chk("gcd_x", {24'd0, x_r}, {24'd0, e[23:16]});
                        chk("latency", lat, {24'd0, e[15:8]});
                        chk("load_pulses", nld, {24'd0, e[7:0]});
                    end
                end
                done_prev = done_o;
            end
        end
    end

    // Driver. hold_n keeps start_i (and a stray ack_i) high for hold_n extra cycles while busy.
    task automatic run_job(input logic [7:0] a, input logic [7:0] b, input logic frc,
                           input int hold_n, input logic e_err, input logic [7:0] e_iter,
                           input logic [7:0] e_x, input logic [7:0] e_lat,
                           input logic [7:0] e_nld, input int ack_delay);
        int n;
        @(negedge clk);
        exp_q.push_back({e_err, e_iter, e_x, e_lat, e_nld});
        a_in = a; b_in = b; force_bad = frc; start_i = 1'b1;
        @(negedge clk);
        if (hold_n > 0) begin
            ack_i = 1'b1;
            repeat (hold_n) @(negedge clk);
            ack_i = 1'b0;
        end
        start_i = 1'b0;
        n = 0;
        while (!done_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done_o) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done_o expected done_o=1 within 200 cycles");
            void'(exp_q.pop_front());
            return;
        end
        for (int i = 0; i < ack_delay; i++) begin
            chk("done_held", {31'd0, done_o}, 32'd1);
            @(negedge clk);
        end
        ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
        force_bad = 1'b0;
        chk("ready_after_ack", {31'd0, ready_o}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; start_i = 1'b0; ack_i = 1'b0; force_bad = 1'b0;
        a_in = '0; b_in = '0;
        #3;
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_ld", {30'd0, ld_x_o, ld_y_o}, 32'd0);
        chk("rst_sel_dir", {30'd0, sel_in_o, sub_dir_o}, 32'd0);
        chk("rst_done_err", {30'd0, done_o, err_o}, 32'd0);
        chk("rst_iter", {24'd0, iter_o}, 32'd0);
        #9 rst_n = 1'b1;

        // T1: gt then lt, gcd 4
        run_job(8'd12, 8'd8, 1'b0, 0, 1'b0, 8'd2, 8'd4, 8'd7, 8'd3, 0);
        // T2: equal operands, only the LOAD pulse
        run_job(8'd9, 8'd9, 1'b0, 0, 1'b0, 8'd0, 8'd9, 8'd3, 8'd1, 0);
        // T3: zero operand
        run_job(8'd0, 8'd5, 1'b0, 0, 1'b1, 8'd0, 8'd0, 8'd3, 8'd1, 0);
        // T4: timeout at MAX_ITER=4
        run_job(8'd100, 8'd1, 1'b0, 0, 1'b1, 8'd4, 8'd0, 8'd11, 8'd5, 0);
        chk("idle_iter_kept", {24'd0, iter_o}, 32'd4);
        chk("idle_err_kept", {31'd0, err_o}, 32'd1);
        // Exactly MAX_ITER subtractions, then eq wins over timeout
        run_job(8'd5, 8'd1, 1'b0, 0, 1'b0, 8'd4, 8'd1, 8'd11, 8'd5, 0);
        // lt path only: 3,12 -> gcd 3 after 3 subtractions
        run_job(8'd3, 8'd12, 1'b0, 0, 1'b0, 8'd3, 8'd3, 8'd9, 8'd4, 0);
        // T5: illegal flags, done held 5 cycles without ack
        run_job(8'd7, 8'd3, 1'b1, 0, 1'b1, 8'd0, 8'd0, 8'd3, 8'd1, 5);
        // start/ack asserted while busy are ignored
        run_job(8'd12, 8'd8, 1'b0, 4, 1'b0, 8'd2, 8'd4, 8'd7, 8'd3, 0);

        // T6: async reset during SUB_Y
        @(negedge clk);
        a_in = 8'd12; b_in = 8'd8; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (!(ld_y_o && sub_dir_o) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_sub_y", {31'd0, ld_y_o && sub_dir_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_ready", {31'd0, ready_o}, 32'd1);
        chk("async_busy_ld", {29'd0, busy_o, ld_x_o, ld_y_o}, 32'd0);
        chk("async_dir_done", {30'd0, sub_dir_o, done_o}, 32'd0);
        chk("async_iter", {24'd0, iter_o}, 32'd0);
        chk("async_err", {31'd0, err_o}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, ready_o}, 32'd1);
        run_job(8'd12, 8'd8, 1'b0, 0, 1'b0, 8'd2, 8'd4, 8'd7, 8'd3, 0);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
